// File: rtl/board_scanout.sv
`default_nettype none
// ============================================================================
// Module   : board_scanout
// Purpose  : Scans the 10x20 game board out as 640x480@60 VGA video. Produces
//            the vsync that clocks the game logic and a 10-bit frame counter
//            used by the game logic for tetrimino selection. The board is
//            captured into a shadow register once per frame, at the start of
//            vertical blanking, so a frame never shows a half-updated board.
//
// Ports    : clk          in   pixel clock (25.175 MHz)
//            rst          in   asynchronous, active-high reset
//            board_in     in   200-bit live board, bit x*20+y = column x,
//                              row y (y=0 is the top row)
//            hsync        out  horizontal sync, active-low
//            vsync        out  vertical sync, active-low (rising edge = tick)
//            frame_tick   out  one-cycle pulse when the snapshot is taken
//            framenumber  out  frame count, wraps 1023 -> 0
//            video_on     out  high inside the visible area
//            rgb          out  4:4:4 colour, zero outside the visible area
//
// Options  : BOARD_SCANOUT_GRID_LINES_EN - when defined, the first pixel
//            column and first line of every cell are drawn 12'h444.
//
// Revision : 1.0 - initial release
// ============================================================================
module board_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CELL     = 20,
    parameter int BOARD_X0 = 220,
    parameter int BOARD_Y0 = 40,
    parameter int BORDER   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [199:0] board_in,
    output logic         hsync,
    output logic         vsync,
    output logic         frame_tick,
    output logic [9:0]   framenumber,
    output logic         video_on,
    output logic [11:0]  rgb
);

    // ------------------------------------------------------------------------
    // Derived geometry
    // ------------------------------------------------------------------------
    localparam int c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW       = $clog2(c_H_TOTAL);
    localparam int c_VW       = $clog2(c_V_TOTAL);
    localparam int c_PW       = (CELL > 1) ? $clog2(CELL) : 1;

    localparam int c_HS_START = H_ACTIVE + H_FP;
    localparam int c_HS_END   = c_HS_START + H_SYNC - 1;
    localparam int c_VS_START = V_ACTIVE + V_FP;
    localparam int c_VS_END   = c_VS_START + V_SYNC - 1;

    // Board rectangle, inclusive bounds
    localparam int c_BX1      = BOARD_X0 + 10 * CELL - 1;
    localparam int c_BY1      = BOARD_Y0 + 20 * CELL - 1;

    // Border rectangle (board grown by BORDER on each side), inclusive
    localparam int c_FX0      = BOARD_X0 - BORDER;
    localparam int c_FX1      = c_BX1 + BORDER;
    localparam int c_FY0      = BOARD_Y0 - BORDER;
    localparam int c_FY1      = c_BY1 + BORDER;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_HW-1:0] r_h_cnt;
    logic [c_VW-1:0] r_v_cnt;
    logic [199:0]    r_shadow;

    // Running cell position; meaningful only inside the board rectangle
    logic [3:0]      r_col;
    logic [c_PW-1:0] r_px;
    logic [4:0]      r_row;
    logic [c_PW-1:0] r_ln;

    // ------------------------------------------------------------------------
    // Combinational decode of the current scan position
    // ------------------------------------------------------------------------
    int          w_h;
    int          w_v;
    int          w_h_next;
    int          w_v_next;
    logic        w_line_end;
    logic        w_snap;
    logic        w_active;
    logic        w_in_board;
    logic        w_in_frame;
    logic        w_hs_region;
    logic        w_vs_region;
    logic [7:0]  w_idx;
    logic        w_cell_on;
    logic [11:0] w_rgb;

    always_comb begin
        w_h        = int'(r_h_cnt);
        w_v        = int'(r_v_cnt);
        w_line_end = (w_h == c_H_TOTAL - 1);
        w_h_next   = w_line_end ? 0 : w_h + 1;
        if (w_line_end) begin
            w_v_next = (w_v == c_V_TOTAL - 1) ? 0 : w_v + 1;
        end else begin
            w_v_next = w_v;
        end

        // First pixel of the first blanking line
        w_snap      = (w_h == 0) && (w_v == V_ACTIVE);

        w_active    = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
        w_hs_region = (w_h >= c_HS_START) && (w_h <= c_HS_END);
        w_vs_region = (w_v >= c_VS_START) && (w_v <= c_VS_END);

        w_in_board  = (w_h >= BOARD_X0) && (w_h <= c_BX1) &&
                      (w_v >= BOARD_Y0) && (w_v <= c_BY1);
        w_in_frame  = (w_h >= c_FX0) && (w_h <= c_FX1) &&
                      (w_v >= c_FY0) && (w_v <= c_FY1);

        // Constant multiply only; the position itself comes from the counters
        w_idx      = 8'(int'(r_col) * 20 + int'(r_row));
        w_cell_on  = (w_idx < 8'd200) ? r_shadow[w_idx] : 1'b0;
    end

    always_comb begin
        w_rgb = 12'h000;
        if (w_active) begin
            if (w_in_board) begin
                w_rgb = w_cell_on ? 12'h0F0 : 12'h111;
`ifdef BOARD_SCANOUT_GRID_LINES_EN
                if ((r_px == '0) || (r_ln == '0)) begin
                    w_rgb = 12'h444;
                end
`endif
            end else if (w_in_frame) begin
                w_rgb = 12'hFFF;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Scan counters, snapshot and registered video outputs.
    // All outputs are produced from the counter state of the same cycle, so
    // they leave the module mutually aligned, one clock behind the counters.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            r_shadow    <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_tick  <= 1'b0;
            framenumber <= '0;
            video_on    <= 1'b0;
            rgb         <= 12'h000;
        end else begin
            r_h_cnt    <= c_HW'(w_h_next);
            r_v_cnt    <= c_VW'(w_v_next);
            hsync      <= ~w_hs_region;
            vsync      <= ~w_vs_region;
            video_on   <= w_active;
            rgb        <= w_rgb;
            frame_tick <= w_snap;
            if (w_snap) begin
                r_shadow    <= board_in;
                framenumber <= framenumber + 10'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Cell counters. They are loaded one step early (when the *next* position
    // is the board origin) so that they read zero exactly while the scan sits
    // on pixel BOARD_X0 / line BOARD_Y0, then advance every CELL pixels/lines.
    // Outside the board they free-run; their values are ignored there.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_px  <= '0;
            r_row <= '0;
            r_ln  <= '0;
        end else begin
            if (w_h_next == BOARD_X0) begin
                r_col <= '0;
                r_px  <= '0;
            end else if (int'(r_px) == CELL - 1) begin
                r_px  <= '0;
                r_col <= 4'(int'(r_col) + 1);
            end else begin
                r_px  <= c_PW'(int'(r_px) + 1);
            end

            if (w_line_end) begin
                if (w_v_next == BOARD_Y0) begin
                    r_row <= '0;
                    r_ln  <= '0;
                end else if (int'(r_ln) == CELL - 1) begin
                    r_ln  <= '0;
                    r_row <= 5'(int'(r_row) + 1);
                end else begin
                    r_ln  <= c_PW'(int'(r_ln) + 1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_board_scanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_board_scanout
// Purpose  : Self-checking bench for board_scanout. A scaled-geometry instance
//            is compared every cycle against a position/arithmetic model; a
//            default-geometry instance is used for line timing; a tiny-frame
//            instance exercises the framenumber wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_board_scanout;

    // Scaled geometry for the main instance: 40 x 50 = 2000 clocks per frame
    localparam int HA = 32, HF = 2, HS = 4, HB = 2, HT = 40;
    localparam int VA = 46, VF = 1, VS = 2, VB = 1, VT = 50;
    localparam int CELL = 2, X0 = 6, Y0 = 3, BORDER = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [199:0] board_in = '0;

    logic         hsync, vsync, frame_tick, video_on;
    logic [9:0]   framenumber;
    logic [11:0]  rgb;

    logic         d_hsync, d_vsync, d_tick, d_von;
    logic [9:0]   d_fn;
    logic [11:0]  d_rgb;

    logic         s_hsync, s_vsync, s_tick, s_von;
    logic [9:0]   s_fn;
    logic [11:0]  s_rgb;

    board_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CELL(CELL), .BOARD_X0(X0), .BOARD_Y0(Y0), .BORDER(BORDER)
    ) u_dut (
        .clk(clk), .rst(rst), .board_in(board_in),
        .hsync(hsync), .vsync(vsync), .frame_tick(frame_tick),
        .framenumber(framenumber), .video_on(video_on), .rgb(rgb)
    );

    board_scanout u_def (
        .clk(clk), .rst(rst), .board_in(board_in),
        .hsync(d_hsync), .vsync(d_vsync), .frame_tick(d_tick),
        .framenumber(d_fn), .video_on(d_von), .rgb(d_rgb)
    );

    // 5 x 5 frame: snapshot every 25 clocks
    board_scanout #(
        .H_ACTIVE(2), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_tiny (
        .clk(clk), .rst(rst), .board_in(board_in),
        .hsync(s_hsync), .vsync(s_vsync), .frame_tick(s_tick),
        .framenumber(s_fn), .video_on(s_von), .rgb(s_rgb)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           t       = 0;   // clock edges since reset release
    int           phase   = 0;
    int           m_fn    = 0;
    logic [199:0] m_shadow = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
        end
    endtask

    // Expected colour of scan position (x,y) given a board image
    function automatic logic [11:0] exp_rgb(input int x, input int y, input logic [199:0] sh);
        int cx, cy;
        if (x >= HA || y >= VA) return 12'h000;
        if (x >= X0 && x < X0 + 10 * CELL && y >= Y0 && y < Y0 + 20 * CELL) begin
            cx = (x - X0) / CELL;
            cy = (y - Y0) / CELL;
`ifdef BOARD_SCANOUT_GRID_LINES_EN
            if ((x - X0) % CELL == 0 || (y - Y0) % CELL == 0) return 12'h444;
`endif
            return sh[cx * 20 + cy] ? 12'h0F0 : 12'h111;
        end
        if (x >= X0 - BORDER && x < X0 + 10 * CELL + BORDER &&
            y >= Y0 - BORDER && y < Y0 + 20 * CELL + BORDER) return 12'hFFF;
        return 12'h000;
    endfunction

    // Model: edge t shows position p = t-1; snapshot when p is (0, VA)
    always @(posedge clk) begin
        int p, x, y;
        if (rst) begin
            t        = 0;
            m_fn     = 0;
            m_shadow = '0;
        end else begin
            t = t + 1;
            p = t - 1;
            x = p % HT;
            y = (p / HT) % VT;
            if (x == 0 && y == VA) begin
                m_shadow = board_in;
                m_fn     = (m_fn + 1) % 1024;
            end
        end
    end

    // Every-cycle comparison of the main instance
    always @(negedge clk) begin
        int p, x, y;
        if (rst || t == 0) begin
            check("rst_hsync", hsync, 1);
            check("rst_vsync", vsync, 1);
            check("rst_tick", frame_tick, 0);
            check("rst_fn", framenumber, 0);
            check("rst_video_on", video_on, 0);
            check("rst_rgb", rgb, 0);
        end else begin
            p = t - 1;
            x = p % HT;
            y = (p / HT) % VT;
            check("hsync", hsync, !(x >= HA + HF && x < HA + HF + HS));
            check("vsync", vsync, !(y >= VA + VF && y < VA + VF + VS));
            check("video_on", video_on, (x < HA && y < VA));
            check("rgb", rgb, exp_rgb(x, y, m_shadow));
            check("frame_tick", frame_tick, (x == 0 && y == VA));
            check("framenumber", framenumber, m_fn);
        end
    end

    // Hand-computed expectations (board = bit0 | bit199 until t=4000)
    always @(negedge clk) begin
        if (phase == 0 && !rst) begin
            case (t)
                10:    check("tiny_fn_pre", s_fn, 0);
                11:    begin check("tiny_fn_first", s_fn, 1); check("tiny_tick_first", s_tick, 1); end
                168:   check("lit_cell00_before_snap", rgb, 12'h111);
                1840:  check("lit_fn_before_snap", framenumber, 0);
                1841:  begin check("lit_fn1", framenumber, 1); check("lit_tick1", frame_tick, 1); end
                1880:  check("lit_vsync_before", vsync, 1);
                1881:  check("lit_vsync_first", vsync, 0);
                1960:  check("lit_vsync_last", vsync, 0);
                1961:  check("lit_vsync_after", vsync, 1);
                2161:  check("lit_black_left", rgb, 12'h000);
                2165:  check("lit_border_left", rgb, 12'hFFF);
                2168:  check("lit_cell00_green", rgb, 12'h0F0);
                2170:  check("lit_cell10_empty", rgb, 12'h111);
                3706:  check("lit_corner_green", rgb, 12'h0F0);
                3707:  check("lit_corner_border", rgb, 12'hFFF);
                3709:  check("lit_corner_black", rgb, 12'h000);
                3841:  begin check("lit_fn2", framenumber, 2); check("lit_tick2", frame_tick, 1); end
                5841:  begin check("lit_fn3", framenumber, 3); check("lit_tick3", frame_tick, 1); end
                25561: check("tiny_fn_1023", s_fn, 1023);
                25585: check("tiny_fn_hold", s_fn, 1023);
                25586: begin check("tiny_fn_wrap", s_fn, 0); check("tiny_tick_wrap", s_tick, 1); end
                default: ;
            endcase
        end
    end

    task automatic finish_bench();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    task automatic wait_t(input int target);
        int guard = 0;
        while (t < target && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (t < target) begin
            n_fail++;
            $display("FAIL wait_t: reached %0d required %0d", t, target);
            finish_bench();
        end
    endtask

    task automatic check_def_reset(input string tag);
        check({tag, "_def_hsync"}, d_hsync, 1);
        check({tag, "_def_vsync"}, d_vsync, 1);
        check({tag, "_def_tick"}, d_tick, 0);
        check({tag, "_def_fn"}, d_fn, 0);
        check({tag, "_def_video_on"}, d_von, 0);
        check({tag, "_def_rgb"}, d_rgb, 0);
    endtask

    // Count clock edges from release until the default instance's hsync falls
    task automatic def_first_fall(input string tag);
        int cnt = 0;
        do begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end while (d_hsync && cnt < 2000);
        check({tag, "_def_hsync_fall"}, cnt, 657);
    endtask

    initial begin
        int cnt;
        logic [223:0] rnd;

        board_in    = '0;
        board_in[0] = 1'b1;
        board_in[199] = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_def_reset("por");
        check("por_tiny_fn", s_fn, 0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Default geometry line timing
        def_first_fall("por");
        cnt = 0;
        do begin @(posedge clk); cnt++; @(negedge clk); end while (!d_hsync && cnt < 2000);
        check("def_hsync_low_width", cnt, 96);
        do begin @(posedge clk); cnt++; @(negedge clk); end while (d_hsync && cnt < 2000);
        check("def_hsync_period", cnt, 800);

        // Random boards, changed mid-frame; model checks they never tear
        wait_t(4000);
        for (int k = 0; k < 15; k++) begin
            for (int i = 0; i < 7; i++) rnd[i*32 +: 32] = $urandom;
            board_in = rnd[199:0];
            wait_t(t + 1337);
        end

        // Tear-free: change bit 0 while frame 14 is already being shown
        wait_t(26100);
        board_in = '0;
        wait_t(28080);
        board_in[0] = 1'b1;
        wait_t(28168);
        check("tear_same_frame", rgb, 12'h111);
        wait_t(29841);
        check("tear_tick", frame_tick, 1);
        wait_t(30168);
        check("tear_next_frame", rgb, 12'h0F0);

        // Mid-frame reset
        wait_t(31200);
        @(posedge clk);
        #2;
        phase = 1;
        rst   = 1'b1;
        @(negedge clk);
        check_def_reset("mid");
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        def_first_fall("mid");

        wait_t(1841);
        check("mid_fn_first_snap", framenumber, 1);
        wait_t(2167);
`ifdef BOARD_SCANOUT_GRID_LINES_EN
        check("mid_grid_pixel", rgb, 12'h444);
`else
        check("mid_grid_pixel", rgb, 12'h0F0);
`endif
        wait_t(2168);
        check("mid_cell_pixel", rgb, 12'h0F0);
        wait_t(2300);
        finish_bench();
    end

endmodule
`default_nettype wire
